nios_onchip_memory_dp: RTL and testbench
========================================

Name: nios_onchip_memory_dp

Overview:
- Parametrised true-dual-port on-chip RAM for the Nios/ReCOP SoC.
- Exposes two Avalon-MM slaves, s1 and s2. Typical wiring: s1 to the Nios data master, s2 to ReCOP or a DMA master.
- Successor to the single-port on-chip memory. Adds configurable width/depth, pipelined read latency with readdatavalid, waitrequest flow control, deterministic cross-port collision rules, and an optional post-reset clear engine.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 10: word-address width; DEPTH = 2**ADDR_W.
- READ_LATENCY, 1: cycles from read accept to readdatavalid; legal values are 1 and 2.
- INIT_FILE, "nios_onchip_memory.hex": configuration-time contents.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset request; gates the clock enable
- clken  in  1  global clock enable
- s1_address, s2_address  in  ADDR_W  word address
- s1_byteenable, s2_byteenable  in  DATA_W/8  byte-lane enables
- s1_chipselect, s2_chipselect  in  1  slave select
- s1_read, s2_read  in  1  read request
- s1_write, s2_write  in  1  write request
- s1_writedata, s2_writedata  in  DATA_W  write data
- s1_readdata, s2_readdata  out  DATA_W  read data
- s1_readdatavalid, s2_readdatavalid  out  1  read data valid
- s1_waitrequest, s2_waitrequest  out  1  stall

Behaviour:
- Clock enable: ce = clken & ~reset_req.
- When ce=0:
  - Nothing advances: no accepts, pipeline frozen.
  - readdata and readdatavalid hold their values.
  - sN_waitrequest=1.
- Accept: port N accepts a command at an edge where chipselect & (read|write) & ~waitrequest & ce.
- Read/write conflict: if read and write are both high, the write wins and the read is dropped (no readdatavalid).
- Write: bytes with byteenable=1 are updated at the accept edge; the other bytes are unchanged. Zero byteenable is a legal no-op.
- Read latency:
  - A read accepted at edge T gives readdata and readdatavalid=1 for exactly one cycle after edge T+READ_LATENCY-1. RL=1: visible in the cycle after accept. RL=2: one extra output register.
  - Back-to-back reads are accepted every cycle.
  - Order is preserved per port.
  - readdata holds its last value when readdatavalid=0.
- Read-during-write (same port or cross port, same address, same edge): the read returns OLD data.
- Write-write collision (same address, same edge):
  - For each byte enabled on both ports, s1 data wins.
  - Bytes enabled on only one port take that port's data.
- Reset:
  - readdata=0, readdatavalid=0 on both ports.
  - Pipeline flushed: in-flight reads are discarded and never produce readdatavalid.
  - waitrequest=1 while reset is high.
  - Without the clear engine, waitrequest=0 on the first edge after reset deasserts (if ce=1).
  - Memory contents are not altered by reset.
- FSM, defined in the package:
  - RST: entered on reset; goes to CLEAR or READY.
  - CLEAR: feature only.
  - READY: serve requests.

Optional Feature:
- Macro: NIOS_ONCHIP_MEM_CLEAR_EN.
- Defined:
  - After reset deasserts, the FSM enters CLEAR.
  - An ADDR_W-bit counter writes zero to address 0..DEPTH-1 through port A, one word per ce cycle.
  - Both waitrequests are held at 1 during CLEAR.
  - After writing DEPTH-1 the counter wraps and the FSM enters READY, so waitrequest drops DEPTH cycles after reset release (with ce=1).
  - reset during CLEAR restarts the clear at address 0.
  - ce=0 pauses the counter.
- Undefined:
  - The CLEAR state and counter are absent.
  - Contents come only from INIT_FILE.

Decomposition:
- Package nios_onchip_mem_pkg:
  - FSM state enum: RST, CLEAR, READY.
  - Legal READ_LATENCY bounds, plus a function computing byteenable width.
- One sub-module, nios_onchip_mem_bank:
  - Byte-lane true-dual-port array with old-data read-during-write.
  - Applies the s1-wins byte merge on collision.
- Top level holds the FSM, clear counter, ce gating, and readdatavalid/readdata pipelines.

Test Plan:
1. Reset release with CLEAR_EN, ADDR_W=4 -> waitrequest=1 for exactly 16 cycles, then 0; reading addresses 0..15 returns 0.
2. RL=2: s1 writes 0xDEADBEEF to address 5, then reads address 5 every cycle for 3 cycles -> readdatavalid pulses on 3 consecutive cycles, 2 edges after each accept, each returning 0xDEADBEEF.
3. Same edge, address 7 (old value 0x00000000): s1 writes 0x11111111 with be=0011, s2 writes 0x22222222 with be=0110 -> address 7 reads 0x00221111.
4. Address 3 holds 0xA5A5A5A5: s2 reads address 3 while s1 writes 0x5A5A5A5A to address 3 on the same edge -> s2 gets 0xA5A5A5A5; a later read gets 0x5A5A5A5A.
5. clken=0 for 3 cycles with an RL=2 read in flight -> waitrequest=1 and readdatavalid is not emitted; it appears 2 ce-cycles after accept, once clken=1.
6. reset asserted one cycle after a read is accepted (RL=2) -> no readdatavalid; readdata=0.

Source files
------------

// File: rtl/nios_onchip_mem_pkg.sv
// Shared types and constants for the dual-port on-chip memory.
package nios_onchip_mem_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/nios_onchip_mem_bank.sv
// Byte-lane true-dual-port array; reads return pre-write data, port A wins shared byte lanes.
module nios_onchip_mem_bank
  import nios_onchip_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_re,
  input  logic                        a_we,
  input  logic [be_width(DATA_W)-1:0] a_be,
  input  logic [ADDR_W-1:0]           a_addr,
  input  logic [DATA_W-1:0]           a_wdata,
  output logic [DATA_W-1:0]           a_rdata,
  input  logic                        b_re,
  input  logic                        b_we,
  input  logic [be_width(DATA_W)-1:0] b_be,
  input  logic [ADDR_W-1:0]           b_addr,
  input  logic [DATA_W-1:0]           b_wdata,
  output logic [DATA_W-1:0]           b_rdata
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [BE_W-1:0][7:0] mem [DEPTH];

  // Port B lanes are written first so a port A write to the same lane lands last.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (b_we && b_be[i]) mem[b_addr][i] <= b_wdata[8*i +: 8];
      if (a_we && a_be[i]) mem[a_addr][i] <= a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/nios_onchip_memory_dp.sv
// Dual Avalon-MM slave on-chip RAM with 1/2-cycle read latency.
// Define NIOS_ONCHIP_MEM_CLEAR_EN to zero-fill the array after every reset.
module nios_onchip_memory_dp
  import nios_onchip_mem_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 10,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "nios_onchip_memory.hex"
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reset_req,
  input  logic                        clken,
  input  logic [ADDR_W-1:0]           s1_address,
  input  logic [be_width(DATA_W)-1:0] s1_byteenable,
  input  logic                        s1_chipselect,
  input  logic                        s1_read,
  input  logic                        s1_write,
  input  logic [DATA_W-1:0]           s1_writedata,
  output logic [DATA_W-1:0]           s1_readdata,
  output logic                        s1_readdatavalid,
  output logic                        s1_waitrequest,
  input  logic [ADDR_W-1:0]           s2_address,
  input  logic [be_width(DATA_W)-1:0] s2_byteenable,
  input  logic                        s2_chipselect,
  input  logic                        s2_read,
  input  logic                        s2_write,
  input  logic [DATA_W-1:0]           s2_writedata,
  output logic [DATA_W-1:0]           s2_readdata,
  output logic                        s2_readdatavalid,
  output logic                        s2_waitrequest
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int RL    = (READ_LATENCY < RL_MIN) ? RL_MIN :
                         (READ_LATENCY > RL_MAX) ? RL_MAX : READ_LATENCY;

  logic   ce;
  state_t state_q, state_d;
  logic   clearing;
  logic [ADDR_W-1:0] clr_addr;

  logic [1:0]             cs, rd, wr, wait_r, rd_acc, wr_acc, rvalid;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][BE_W-1:0]   be;
  logic [1:0][DATA_W-1:0] wdata, bank_q, rdata;

  assign ce    = clken & ~reset_req;
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};
  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};

  always_ff @(posedge clk) begin
    if (reset)   state_q <= RST;
    else if (ce) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef NIOS_ONCHIP_MEM_CLEAR_EN
      RST:     state_d = CLEAR;
`else
      RST:     state_d = READY;
`endif
      CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_d = READY;
      READY:   state_d = READY;
      default: state_d = RST;
    endcase
  end

`ifdef NIOS_ONCHIP_MEM_CLEAR_EN
  // Address 0 is written on the RST->CLEAR edge, so the fill takes exactly DEPTH ce edges.
  logic [ADDR_W-1:0] clr_cnt;
  always_ff @(posedge clk) begin
    if (reset)                 clr_cnt <= '0;
    else if (ce && clearing)   clr_cnt <= clr_cnt + ADDR_W'(1);
  end
  assign clearing = ~reset & (state_q != READY);
  assign clr_addr = clr_cnt;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [RL-1:0] vld_pipe;

    assign wait_r[p] = reset | ~ce | (state_q != READY);
    assign rd_acc[p] = cs[p] & rd[p] & ~wr[p] & ~wait_r[p];
    assign wr_acc[p] = cs[p] & wr[p] & ~wait_r[p];

    always_ff @(posedge clk) begin
      if (reset)   vld_pipe <= '0;
      else if (ce) vld_pipe <= (vld_pipe << 1) | RL'(rd_acc[p]);
    end
    assign rvalid[p] = vld_pipe[RL-1];

    if (RL == 2) begin : g_rl2
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (reset)                  rdata_q <= '0;
        else if (ce && vld_pipe[0]) rdata_q <= bank_q[p];
      end
      assign rdata[p] = rdata_q;
    end else begin : g_rl1
      assign rdata[p] = bank_q[p];
    end
  end

  nios_onchip_mem_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .a_re    (rd_acc[0]),
    .a_we    (wr_acc[0] | (clearing & ce)),
    .a_be    (clearing ? {BE_W{1'b1}} : be[0]),
    .a_addr  (clearing ? clr_addr : addr[0]),
    .a_wdata (clearing ? '0 : wdata[0]),
    .a_rdata (bank_q[0]),
    .b_re    (rd_acc[1]),
    .b_we    (wr_acc[1]),
    .b_be    (be[1]),
    .b_addr  (addr[1]),
    .b_wdata (wdata[1]),
    .b_rdata (bank_q[1])
  );

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvalid[0];
  assign s1_waitrequest   = wait_r[0];
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvalid[1];
  assign s2_waitrequest   = wait_r[1];

endmodule

// File: tb/tb_nios_onchip_memory_dp.sv
// Directed table + randomized scoreboard bench for nios_onchip_memory_dp (RL=2, 16 words).
module tb_nios_onchip_memory_dp;

  localparam int DW = 32, AW = 4, RL = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic reset, reset_req, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

  always #5 clk = ~clk;

  nios_onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );

  typedef struct {
    logic w1; logic [3:0] a1, be1; logic [31:0] d1;
    logic w2; logic [3:0] a2, be2; logic [31:0] d2;
    logic [3:0] ra; logic [31:0] exp;
  } vec_t;

  typedef struct { int idx; logic [31:0] d; } pend_t;

  int n_chk = 0, n_fail = 0;
  vec_t vecs [8];
  logic [31:0] mem [DEPTH];
  pend_t pq [2][$];
  logic [31:0] last_rd [2];
  int cec = 0;

  logic st_clk, st_rr;
  logic st_cs [2], st_rd [2], st_wr [2];
  logic [3:0] st_a [2], st_be [2];
  logic [31:0] st_d [2];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic c, input logic r, input logic w,
                          input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      s1_chipselect = c; s1_read = r; s1_write = w; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = c; s2_read = r; s2_write = w; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask

  task automatic idle();
    set_port(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
  endtask

  task automatic get_out(input int p, output logic v, output logic [31:0] d, output logic wt);
    v  = (p == 0) ? s1_readdatavalid : s2_readdatavalid;
    d  = (p == 0) ? s1_readdata      : s2_readdata;
    wt = (p == 0) ? s1_waitrequest   : s2_waitrequest;
  endtask

  task automatic wait_valid(input int p, input logic [31:0] exp, input string nm);
    logic v, wt; logic [31:0] d; bit got;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      get_out(p, v, d, wt);
      if (v === 1'b1) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s: readdatavalid never seen, expected data %h", nm, exp);
    end else chk(nm, d, exp);
  endtask

  task automatic read_chk(input int p, input logic [3:0] a, input logic [31:0] exp, input string nm);
    set_port(p, 1'b1, 1'b1, 1'b0, a, 4'hF, 32'h0);
    tick();
    set_port(p, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    wait_valid(p, exp, nm);
  endtask

  task automatic wait_ready(input string nm);
    bit rdy;
    rdy = 0;
    for (int i = 0; i < 40 && !rdy; i++) begin
      if (s1_waitrequest === 1'b0) rdy = 1;
      else tick();
    end
    if (!rdy) begin
      n_chk++; n_fail++;
      $display("FAIL %s: waitrequest stuck at 1", nm);
    end
  endtask

  // One randomized cycle: check outputs from the previous edge, then advance the model.
  task automatic rcyc();
    logic ce, v, wt, exp_v; logic [31:0] d;
    clken = st_clk; reset_req = st_rr;
    for (int p = 0; p < 2; p++) set_port(p, st_cs[p], st_rd[p], st_wr[p], st_a[p], st_be[p], st_d[p]);
    @(negedge clk);
    ce = st_clk & ~st_rr;
    for (int p = 0; p < 2; p++) begin
      while (pq[p].size() > 0 && pq[p][0].idx < cec - (RL - 1)) void'(pq[p].pop_front());
      exp_v = (pq[p].size() > 0) && (pq[p][0].idx == cec - (RL - 1));
      if (exp_v) last_rd[p] = pq[p][0].d;
      get_out(p, v, d, wt);
      chk($sformatf("rnd_wait%0d", p + 1), 32'(wt), 32'(!ce));
      chk($sformatf("rnd_valid%0d", p + 1), 32'(v), 32'(exp_v));
      chk($sformatf("rnd_rdata%0d", p + 1), d, last_rd[p]);
    end
    if (ce) begin
      cec++;
      for (int p = 0; p < 2; p++)
        if (st_cs[p] && st_rd[p] && !st_wr[p]) pq[p].push_back('{cec, mem[st_a[p]]});
      for (int p = 1; p >= 0; p--)
        if (st_cs[p] && st_wr[p])
          for (int b = 0; b < 4; b++)
            if (st_be[p][b]) mem[st_a[p]][8*b +: 8] = st_d[p][8*b +: 8];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic v, wt; logic [31:0] d; int cnt;

    vecs[0] = '{1'b1, 4'd7,  4'hF, 32'h00000000, 1'b0, 4'd0,  4'h0, 32'h0,          4'd7,  32'h00000000};
    vecs[1] = '{1'b1, 4'd7,  4'h3, 32'h11111111, 1'b1, 4'd7,  4'h6, 32'h22222222,   4'd7,  32'h00221111};
    vecs[2] = '{1'b1, 4'd3,  4'hF, 32'hA5A5A5A5, 1'b1, 4'd9,  4'hF, 32'h01020304,   4'd3,  32'hA5A5A5A5};
    vecs[3] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  4'h0, 32'h0,          4'd9,  32'h01020304};
    vecs[4] = '{1'b1, 4'd9,  4'h0, 32'hFFFFFFFF, 1'b0, 4'd0,  4'h0, 32'h0,          4'd9,  32'h01020304};
    vecs[5] = '{1'b1, 4'd7,  4'h1, 32'h00000000, 1'b1, 4'd7,  4'h8, 32'hCAFEBABE,   4'd7,  32'hCA221100};
    vecs[6] = '{1'b1, 4'd12, 4'hF, 32'h12345678, 1'b1, 4'd12, 4'hF, 32'h9ABCDEF0,   4'd12, 32'h12345678};
    vecs[7] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd12, 4'hC, 32'hFFFFFFFF,   4'd12, 32'hFFFF5678};

    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    repeat (3) tick();
    for (int p = 0; p < 2; p++) begin
      get_out(p, v, d, wt);
      chk($sformatf("rst_valid%0d", p + 1), 32'(v), 32'd0);
      chk($sformatf("rst_rdata%0d", p + 1), d, 32'h0);
      chk($sformatf("rst_wait%0d", p + 1), 32'(wt), 32'd1);
    end

    // Count cycles with waitrequest high after release, including the one before the first edge.
    reset = 1'b0;
    #1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (s1_waitrequest !== 1'b1) break;
      cnt++;
      tick();
    end
`ifdef NIOS_ONCHIP_MEM_CLEAR_EN
    chk("release_wait_cycles", cnt, DEPTH);
`else
    chk("release_wait_cycles", cnt, 1);
`endif
    chk("release_wait2", 32'(s2_waitrequest), 32'd0);
`ifdef NIOS_ONCHIP_MEM_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) read_chk(0, 4'(a), 32'h0, $sformatf("clear_zero%0d", a));
`endif

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].w1 || vecs[i].w2) begin
        set_port(0, vecs[i].w1, 1'b0, vecs[i].w1, vecs[i].a1, vecs[i].be1, vecs[i].d1);
        set_port(1, vecs[i].w2, 1'b0, vecs[i].w2, vecs[i].a2, vecs[i].be2, vecs[i].d2);
        tick();
        idle();
      end
      read_chk(0, vecs[i].ra, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back reads at RL=2
    set_port(0, 1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF);
    tick();
    set_port(0, 1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'h0);
    tick();
    chk("burst_v0", 32'(s1_readdatavalid), 32'd0);
    tick();
    chk("burst_v1", 32'(s1_readdatavalid), 32'd1);
    chk("burst_d1", s1_readdata, 32'hDEADBEEF);
    tick();
    idle();
    chk("burst_v2", 32'(s1_readdatavalid), 32'd1);
    chk("burst_d2", s1_readdata, 32'hDEADBEEF);
    tick();
    chk("burst_v3", 32'(s1_readdatavalid), 32'd1);
    chk("burst_d3", s1_readdata, 32'hDEADBEEF);
    tick();
    chk("burst_v4", 32'(s1_readdatavalid), 32'd0);

    // Cross-port read-during-write returns old data
    set_port(0, 1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'h5A5A5A5A);
    set_port(1, 1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 32'h0);
    tick();
    idle();
    wait_valid(1, 32'hA5A5A5A5, "rdw_old");
    read_chk(0, 4'd3, 32'h5A5A5A5A, "rdw_new");

    // Read and write together: write wins, no read response
    set_port(0, 1'b1, 1'b1, 1'b1, 4'd3, 4'hF, 32'h77777777);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rw_noval%0d", i), 32'(s1_readdatavalid), 32'd0);
    end
    read_chk(0, 4'd3, 32'h77777777, "rw_write_won");

    // clken stall with a read in flight
    set_port(0, 1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'h0);
    tick();
    idle();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_wait%0d", i), 32'(s1_waitrequest), 32'd1);
      chk($sformatf("stall_noval%0d", i), 32'(s1_readdatavalid), 32'd0);
    end
    clken = 1'b1;
    tick();
    chk("stall_val", 32'(s1_readdatavalid), 32'd1);
    chk("stall_data", s1_readdata, 32'hDEADBEEF);
    tick();
    chk("stall_val_off", 32'(s1_readdatavalid), 32'd0);

    // Reset one cycle after accept flushes the read
    set_port(0, 1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'h0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    chk("flush_val", 32'(s1_readdatavalid), 32'd0);
    chk("flush_data", s1_readdata, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_noval%0d", i), 32'(s1_readdatavalid), 32'd0);
    end
    wait_ready("flush_ready");

    // Randomized phase against the scoreboard model
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    st_rr = 1'b0; st_clk = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      st_cs[0] = 1'b1; st_rd[0] = 1'b0; st_wr[0] = 1'b1;
      st_a[0] = 4'(a); st_be[0] = 4'hF; st_d[0] = $urandom;
      st_cs[1] = 1'b0; st_rd[1] = 1'b0; st_wr[1] = 1'b0;
      st_a[1] = 4'd0; st_be[1] = 4'h0; st_d[1] = 32'h0;
      rcyc();
    end
    for (int n = 0; n < 600; n++) begin
      st_clk = ($urandom_range(0, 9) != 0);
      st_rr  = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++) begin
        st_cs[p] = ($urandom_range(0, 3) != 0);
        st_rd[p] = 1'($urandom);
        st_wr[p] = 1'($urandom);
        st_a[p]  = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        st_be[p] = 4'($urandom);
        st_d[p]  = $urandom;
      end
      rcyc();
    end
    st_clk = 1'b1; st_rr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      st_cs[p] = 1'b0; st_rd[p] = 1'b0; st_wr[p] = 1'b0;
    end
    repeat (4) rcyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
